// File: rtl/digit_pair_collector_pkg.sv
// Shared keyboard definitions: scan-code constants, entry FSM states and
// the scan-code to BCD digit decoder used by keypad consumers.
package kbd_pkg;

  localparam logic [7:0] SC_BREAK = 8'hF0;
  localparam logic [7:0] SC_EXT   = 8'hE0;
  localparam logic [7:0] SC_ENTER = 8'h5A;
  localparam logic [7:0] SC_BKSP  = 8'h66;
  localparam logic [7:0] SC_DIG0  = 8'h45;
  localparam logic [7:0] SC_DIG1  = 8'h16;
  localparam logic [7:0] SC_DIG2  = 8'h1E;
  localparam logic [7:0] SC_DIG3  = 8'h26;
  localparam logic [7:0] SC_DIG4  = 8'h25;
  localparam logic [7:0] SC_DIG5  = 8'h2E;
  localparam logic [7:0] SC_DIG6  = 8'h36;
  localparam logic [7:0] SC_DIG7  = 8'h3D;
  localparam logic [7:0] SC_DIG8  = 8'h3E;
  localparam logic [7:0] SC_DIG9  = 8'h46;

  typedef enum logic [1:0] {
    WAIT_D1,
    WAIT_D2,
    READY,
    HOLD
  } entry_state_t;

  // Returns {is_digit, bcd}; non-digit codes return all zeros.
  function automatic logic [4:0] scan_to_bcd(input logic [7:0] code);
    logic [4:0] result;
    result = 5'h00;
    case (code)
      SC_DIG0: result = {1'b1, 4'd0};
      SC_DIG1: result = {1'b1, 4'd1};
      SC_DIG2: result = {1'b1, 4'd2};
      SC_DIG3: result = {1'b1, 4'd3};
      SC_DIG4: result = {1'b1, 4'd4};
      SC_DIG5: result = {1'b1, 4'd5};
      SC_DIG6: result = {1'b1, 4'd6};
      SC_DIG7: result = {1'b1, 4'd7};
      SC_DIG8: result = {1'b1, 4'd8};
      SC_DIG9: result = {1'b1, 4'd9};
      default: result = 5'h00;
    endcase
    return result;
  endfunction

endpackage

// File: rtl/digit_pair_collector_if.sv
// Scan-byte input and committed digit-pair output of the keypad collector.
interface digit_pair_collector_if;

  logic [7:0] scan_code;
  logic       scan_valid;
  logic [3:0] digit1;
  logic [3:0] digit2;
  logic       pair_valid;
  logic       pair_ready;
  logic [1:0] digit_count;
  logic       key_error;

  modport master (
    output scan_code, scan_valid, pair_ready,
    input  digit1, digit2, pair_valid, digit_count, key_error
  );

  modport slave (
    input  scan_code, scan_valid, pair_ready,
    output digit1, digit2, pair_valid, digit_count, key_error
  );

endinterface

// File: rtl/digit_pair_collector_prefix.sv
// Strips PS/2 E0/F0 prefixes and presents make codes with an extended flag;
// release bytes are swallowed so consumers only see key presses.
module scan_prefix_filter
  import kbd_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] i_scan_code,
  input  logic       i_scan_valid,
  output logic       o_make_valid,
  output logic [7:0] o_make_code,
  output logic       o_make_ext
);

  logic r_brkFlag;
  logic r_extFlag;
  logic w_isPrefix;

  assign w_isPrefix = (i_scan_code == SC_BREAK) || (i_scan_code == SC_EXT);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_brkFlag <= 1'b0;
      r_extFlag <= 1'b0;
    end else if (i_scan_valid) begin
      if (i_scan_code == SC_EXT) begin
        r_extFlag <= 1'b1;
      end else if (i_scan_code == SC_BREAK) begin
        r_brkFlag <= 1'b1;
      end else begin
        r_brkFlag <= 1'b0;
        r_extFlag <= 1'b0;
      end
    end
  end

  assign o_make_valid = i_scan_valid && !w_isPrefix && !r_brkFlag;
  assign o_make_code  = i_scan_code;
  assign o_make_ext   = r_extFlag;

endmodule

// File: rtl/digit_pair_collector.sv
// Assembles two decimal key presses into a BCD pair and hands it downstream
// with a valid/ready handshake once Enter commits the entry.
module digit_pair_collector
  import kbd_pkg::*;
#(
  parameter int NUM_DIGITS       = 2,
  parameter bit HOLD_ON_OVERFLOW = 1'b1
) (
  input  logic                    clk,
  input  logic                    reset,
  digit_pair_collector_if.slave   bus
);

  generate
    if (NUM_DIGITS != 2) begin : g_badDigits
      $error("digit_pair_collector supports only NUM_DIGITS == 2");
    end
  endgenerate

  entry_state_t r_state, w_nextState;
  logic [3:0]   r_digit1, w_nextDigit1;
  logic [3:0]   r_digit2, w_nextDigit2;
  logic [1:0]   r_count, w_nextCount;
  logic         r_pairValid, w_nextPairValid;
  logic         r_keyError, w_nextKeyError;

  logic         w_makeValid;
  logic [7:0]   w_makeCode;
  logic         w_makeExt;
  logic [4:0]   w_bcd;
  logic         w_isDigit;
  logic         w_isEnter;
  logic         w_isBksp;
  logic         w_isOther;

  scan_prefix_filter u_prefix (
    .clk          (clk),
    .reset        (reset),
    .i_scan_code  (bus.scan_code),
    .i_scan_valid (bus.scan_valid),
    .o_make_valid (w_makeValid),
    .o_make_code  (w_makeCode),
    .o_make_ext   (w_makeExt)
  );

  // Extended codes never decode as digits or Backspace; Enter works either way.
  assign w_bcd     = scan_to_bcd(w_makeCode);
  assign w_isDigit = w_makeValid && !w_makeExt && w_bcd[4];
  assign w_isEnter = w_makeValid && (w_makeCode == SC_ENTER);
  assign w_isBksp  = w_makeValid && !w_makeExt && (w_makeCode == SC_BKSP);
  assign w_isOther = w_makeValid && !w_isDigit && !w_isEnter && !w_isBksp;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= WAIT_D1;
      r_digit1    <= 4'h0;
      r_digit2    <= 4'h0;
      r_count     <= 2'd0;
      r_pairValid <= 1'b0;
      r_keyError  <= 1'b0;
    end else begin
      r_state     <= w_nextState;
      r_digit1    <= w_nextDigit1;
      r_digit2    <= w_nextDigit2;
      r_count     <= w_nextCount;
      r_pairValid <= w_nextPairValid;
      r_keyError  <= w_nextKeyError;
    end
  end

  always_comb begin
    w_nextState     = r_state;
    w_nextDigit1    = r_digit1;
    w_nextDigit2    = r_digit2;
    w_nextCount     = r_count;
    w_nextPairValid = r_pairValid;
    w_nextKeyError  = 1'b0;
    if (r_state != HOLD && w_isOther) begin
      w_nextKeyError = 1'b1;
    end
    case (r_state)
      WAIT_D1: begin
        if (w_isDigit) begin
          w_nextDigit1 = w_bcd[3:0];
          w_nextCount  = 2'd1;
          w_nextState  = WAIT_D2;
        end
      end
      WAIT_D2: begin
        if (w_isDigit) begin
          w_nextDigit2 = w_bcd[3:0];
          w_nextCount  = 2'd2;
          w_nextState  = READY;
        end else if (w_isBksp) begin
          w_nextCount = 2'd0;
          w_nextState = WAIT_D1;
        end
      end
      READY: begin
        if (w_isEnter) begin
          w_nextPairValid = 1'b1;
          w_nextState     = HOLD;
        end else if (w_isBksp) begin
          w_nextCount = 2'd1;
          w_nextState = WAIT_D2;
        end else if (w_isDigit && !HOLD_ON_OVERFLOW) begin
          w_nextDigit1 = w_bcd[3:0];
          w_nextCount  = 2'd1;
          w_nextState  = WAIT_D2;
        end
      end
      HOLD: begin
        if (r_pairValid && bus.pair_ready) begin
          w_nextPairValid = 1'b0;
          w_nextCount     = 2'd0;
          w_nextState     = WAIT_D1;
        end
      end
      default: w_nextState = WAIT_D1;
    endcase
  end

  assign bus.digit1      = r_digit1;
  assign bus.digit2      = r_digit2;
  assign bus.pair_valid  = r_pairValid;
  assign bus.digit_count = r_count;
  assign bus.key_error   = r_keyError;

  a_bcdRange : assert property (@(posedge clk) disable iff (reset)
    r_pairValid |-> (r_digit1 <= 4'd9 && r_digit2 <= 4'd9));

endmodule

// File: tb/tb_digit_pair_collector.sv
// Scoreboard bench for digit_pair_collector: expected pairs are queued as
// entries are keyed in and popped when the DUT hands a pair downstream.
module tb_digit_pair_collector;
  import kbd_pkg::*;

  logic       clk = 1'b0;
  logic       reset;
  int         vecCount  = 0;
  int         missCount = 0;
  logic [7:0] expQ[$];
  logic [7:0] popped;
  logic       ok;

  digit_pair_collector_if bus();

  digit_pair_collector #(
    .NUM_DIGITS       (2),
    .HOLD_ON_OVERFLOW (1'b1)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [7:0] observed,
                             input logic [7:0] expected);
    vecCount++;
    if (observed !== expected) begin
      missCount++;
      $display("[TB] FAIL %s: observed %0h, expected %0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic [7:0] code);
    @(posedge clk);
    #1;
    bus.scan_code  = code;
    bus.scan_valid = 1'b1;
    @(posedge clk);
    #1;
    bus.scan_valid = 1'b0;
  endtask

  // Every handshake must match the oldest queued pair.
  always @(negedge clk) begin
    if (!reset && bus.pair_valid && bus.pair_ready) begin
      if (expQ.size() == 0) begin
        checkOutput("unexpected pair", {bus.digit1, bus.digit2}, 8'hFF);
      end else begin
        popped = expQ.pop_front();
        checkOutput("pair", {bus.digit1, bus.digit2}, popped);
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    bus.scan_code  = 8'h00;
    bus.scan_valid = 1'b0;
    bus.pair_ready = 1'b1;
    reset          = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checkOutput("rst pair_valid", 8'(bus.pair_valid), 8'd0);
    checkOutput("rst digits", {bus.digit1, bus.digit2}, 8'h00);
    checkOutput("rst count", 8'(bus.digit_count), 8'd0);
    checkOutput("rst key_error", 8'(bus.key_error), 8'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;

    // Make/break sequence with ready already high
    applyStimulus(8'h16); applyStimulus(8'hF0); applyStimulus(8'h16);
    applyStimulus(8'h2E); applyStimulus(8'hF0); applyStimulus(8'h2E);
    expQ.push_back(8'h15);
    applyStimulus(8'h5A);
    @(negedge clk);
    checkOutput("t1 valid after enter", 8'(bus.pair_valid), 8'd1);
    checkOutput("t1 digits", {bus.digit1, bus.digit2}, 8'h15);
    @(negedge clk);
    checkOutput("t1 valid one cycle", 8'(bus.pair_valid), 8'd0);
    checkOutput("t1 count cleared", 8'(bus.digit_count), 8'd0);
    applyStimulus(8'hF0); applyStimulus(8'h5A);
    @(negedge clk);
    checkOutput("t1 release ignored", 8'(bus.digit_count), 8'd0);

    // Backspace then back-pressure for 10 cycles
    bus.pair_ready = 1'b0;
    applyStimulus(8'h3D); applyStimulus(8'h66);
    applyStimulus(8'h46); applyStimulus(8'h1E);
    expQ.push_back(8'h92);
    applyStimulus(8'h5A);
    ok = 1'b1;
    repeat (10) begin
      @(negedge clk);
      if (!(bus.pair_valid === 1'b1 && {bus.digit1, bus.digit2} === 8'h92)) ok = 1'b0;
    end
    checkOutput("t2 held stable", 8'(ok), 8'd1);
    @(posedge clk);
    #1;
    bus.pair_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    checkOutput("t2 valid dropped", 8'(bus.pair_valid), 8'd0);
    checkOutput("t2 digits kept", {bus.digit1, bus.digit2}, 8'h92);

    // Unknown make code
    applyStimulus(8'h1C);
    @(negedge clk);
    checkOutput("t3 key_error pulse", 8'(bus.key_error), 8'd1);
    checkOutput("t3 count still 0", 8'(bus.digit_count), 8'd0);
    @(negedge clk);
    checkOutput("t3 key_error ends", 8'(bus.key_error), 8'd0);
    applyStimulus(8'h45);
    @(negedge clk);
    checkOutput("t3 count after 45", 8'(bus.digit_count), 8'd1);
    applyStimulus(8'h26);
    expQ.push_back(8'h03);
    applyStimulus(8'h5A);
    repeat (2) @(negedge clk);
    checkOutput("t3 count after accept", 8'(bus.digit_count), 8'd0);

    // Keys injected during HOLD are dropped, flags still tracked
    bus.pair_ready = 1'b0;
    applyStimulus(8'h36); applyStimulus(8'h3E);
    expQ.push_back(8'h68);
    applyStimulus(8'h5A);
    applyStimulus(8'h16); applyStimulus(8'hF0); applyStimulus(8'h16);
    @(negedge clk);
    checkOutput("t4 hold valid", 8'(bus.pair_valid), 8'd1);
    checkOutput("t4 hold digits", {bus.digit1, bus.digit2}, 8'h68);
    checkOutput("t4 hold count", 8'(bus.digit_count), 8'd2);
    @(posedge clk);
    #1;
    bus.pair_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    checkOutput("t4 accepted", 8'(bus.pair_valid), 8'd0);
    applyStimulus(8'h45);
    @(negedge clk);
    checkOutput("t4 count after 45", 8'(bus.digit_count), 8'd1);
    checkOutput("t4 digit1 is 0", 8'(bus.digit1), 8'd0);
    applyStimulus(8'h66);
    @(negedge clk);
    checkOutput("t4 backspace", 8'(bus.digit_count), 8'd0);

    // Extended Enter with one digit, then an extended arrow
    applyStimulus(8'h16);
    applyStimulus(8'hE0); applyStimulus(8'h5A);
    repeat (2) @(negedge clk);
    checkOutput("t5 no pair", 8'(bus.pair_valid), 8'd0);
    checkOutput("t5 count stays 1", 8'(bus.digit_count), 8'd1);
    applyStimulus(8'hE0); applyStimulus(8'h75);
    @(negedge clk);
    checkOutput("t5 arrow key_error", 8'(bus.key_error), 8'd1);
    applyStimulus(8'h66);
    @(negedge clk);
    checkOutput("t5 backspace", 8'(bus.digit_count), 8'd0);

    // Overflow digit held in READY, then reset aborts the entry
    applyStimulus(8'h3E); applyStimulus(8'h25);
    applyStimulus(8'h16);
    @(negedge clk);
    checkOutput("t6 overflow count", 8'(bus.digit_count), 8'd2);
    checkOutput("t6 overflow digits", {bus.digit1, bus.digit2}, 8'h84);
    @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    checkOutput("t6 reset count", 8'(bus.digit_count), 8'd0);
    checkOutput("t6 reset valid", 8'(bus.pair_valid), 8'd0);
    checkOutput("t6 reset digits", {bus.digit1, bus.digit2}, 8'h00);
    applyStimulus(8'h5A);
    ok = 1'b1;
    repeat (4) begin
      @(negedge clk);
      if (bus.pair_valid !== 1'b0) ok = 1'b0;
    end
    checkOutput("t6 no aborted pair", 8'(ok), 8'd1);

    checkOutput("scoreboard drained", 8'(expQ.size()), 8'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
    $finish;
  end

endmodule
